// File: rtl/sh2_int_accept.sv
// sh2_int_accept: hardware-interrupt exception-entry sequencer between the INTC and the CPU core.
// Accepts a request at an instruction boundary, fetches its vector, stacks SR/PC and loads the handler PC.
module sh2_int_accept #(
   parameter logic [7:0] NMI_VEC = 8'd11
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        CE_R,
   input  logic        CE_F,
   input  logic [3:0]  SR_I,
   input  logic        INST_BOUND,
   input  logic [31:0] PC,
   input  logic [31:0] SR,
   input  logic [31:0] R15,
   input  logic [31:0] VBR,
   output logic [3:0]  INT_MASK,
   input  logic        INT_REQ,
   input  logic [3:0]  INT_LVL,
   input  logic [7:0]  INT_VEC,
   output logic        INT_ACP,
   output logic        INT_ACK,
   output logic        VECT_REQ,
   input  logic        VECT_WAIT,
   output logic [31:0] MEM_A,
   output logic [31:0] MEM_DO,
   input  logic [31:0] MEM_DI,
   output logic [3:0]  MEM_BA,
   output logic        MEM_WE,
   output logic        MEM_REQ,
   input  logic        MEM_WAIT,
   output logic        EXC_BUSY,
   output logic        EXC_DONE,
   output logic [31:0] NEW_PC,
   output logic [31:0] NEW_R15,
   output logic [3:0]  NEW_SR_I
);

   localparam int unsigned AW = 32;
   localparam int unsigned LW = 4;
   localparam int unsigned VW = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_VREQ,
      S_VWAIT,
      S_PSR,
      S_PPC,
      S_RVEC,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [LW-1:0] lvl_q, lvl_d;
   logic [AW-1:0] r15_q, r15_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] sr_q, sr_d;
   logic [AW-1:0] di_q, di_d;
   logic [VW-1:0] vec_q, vec_d;
   logic          vec_ok_q, vec_ok_d;

   logic          int_acp_q, int_acp_d;
   logic          int_ack_q, int_ack_d;
   logic          vect_req_q, vect_req_d;
   logic [AW-1:0] mem_a_q, mem_a_d;
   logic [AW-1:0] mem_do_q, mem_do_d;
   logic          mem_we_q, mem_we_d;
   logic          mem_req_q, mem_req_d;
   logic          exc_busy_q, exc_busy_d;
   logic          exc_done_q, exc_done_d;
   logic [AW-1:0] new_pc_q, new_pc_d;
   logic [AW-1:0] new_r15_q, new_r15_d;
   logic [LW-1:0] new_sr_i_q, new_sr_i_d;

   logic          accept_c;
   logic          mem_done_c;

   // NMI vector bypasses the level comparison
   assign accept_c   = INT_REQ & INST_BOUND & ((INT_LVL > SR_I) | (INT_VEC == NMI_VEC));
   assign mem_done_c = mem_req_q & ~MEM_WAIT;

   always_comb begin
      state_d    = state_q;
      lvl_d      = lvl_q;
      r15_d      = r15_q;
      pc_d       = pc_q;
      sr_d       = sr_q;
      di_d       = di_q;
      vec_d      = vec_q;
      vec_ok_d   = vec_ok_q;
      int_acp_d  = int_acp_q;
      int_ack_d  = int_ack_q;
      vect_req_d = vect_req_q;
      mem_a_d    = mem_a_q;
      mem_do_d   = mem_do_q;
      mem_we_d   = mem_we_q;
      mem_req_d  = mem_req_q;
      exc_busy_d = exc_busy_q;
      exc_done_d = exc_done_q;
      new_pc_d   = new_pc_q;
      new_r15_d  = new_r15_q;
      new_sr_i_d = new_sr_i_q;

      // single-CE_R strobes fall on the next rising-phase enable
      if (CE_R) begin
         int_acp_d  = 1'b0;
         int_ack_d  = 1'b0;
         exc_done_d = 1'b0;
      end

      unique case (state_q)
         S_IDLE: begin
            if (CE_R && accept_c) begin
               state_d    = S_VREQ;
               lvl_d      = INT_LVL;
               r15_d      = R15;
               pc_d       = PC;
               sr_d       = SR;
               vec_ok_d   = 1'b0;
               int_acp_d  = 1'b1;
               vect_req_d = 1'b1;
               exc_busy_d = 1'b1;
            end
         end
         S_VREQ: begin
            if (CE_F) begin
               state_d    = S_VWAIT;
               vect_req_d = 1'b0;
            end
         end
         S_VWAIT: begin
            if (CE_F && !vec_ok_q && !VECT_WAIT) begin
               vec_d    = INT_VEC;
               vec_ok_d = 1'b1;
            end
            if (CE_R && vec_ok_q) begin
               state_d   = S_PSR;
               vec_ok_d  = 1'b0;
               int_ack_d = 1'b1;
               mem_req_d = 1'b1;
               mem_we_d  = 1'b1;
               mem_a_d   = r15_q - AW'(4);
               mem_do_d  = sr_q;
            end
         end
         S_PSR: begin
            if (CE_R && mem_done_c) begin
               state_d  = S_PPC;
               mem_a_d  = r15_q - AW'(8);
               mem_do_d = pc_q;
            end
         end
         S_PPC: begin
            if (CE_R && mem_done_c) begin
               state_d  = S_RVEC;
               mem_we_d = 1'b0;
               mem_a_d  = VBR + AW'({vec_q, 2'b00});
               mem_do_d = '0;
            end
         end
         S_RVEC: begin
            if (CE_R && mem_done_c) begin
               state_d   = S_DONE;
               di_d      = MEM_DI;
               mem_req_d = 1'b0;
               mem_a_d   = '0;
            end
         end
         S_DONE: begin
            if (CE_R) begin
               state_d    = S_IDLE;
               new_pc_d   = di_q;
               new_r15_d  = r15_q - AW'(8);
               new_sr_i_d = lvl_q;
               exc_done_d = 1'b1;
               exc_busy_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= S_IDLE;
         lvl_q      <= '0;
         r15_q      <= '0;
         pc_q       <= '0;
         sr_q       <= '0;
         di_q       <= '0;
         vec_q      <= '0;
         vec_ok_q   <= 1'b0;
         int_acp_q  <= 1'b0;
         int_ack_q  <= 1'b0;
         vect_req_q <= 1'b0;
         mem_a_q    <= '0;
         mem_do_q   <= '0;
         mem_we_q   <= 1'b0;
         mem_req_q  <= 1'b0;
         exc_busy_q <= 1'b0;
         exc_done_q <= 1'b0;
         new_pc_q   <= '0;
         new_r15_q  <= '0;
         new_sr_i_q <= '0;
      end else begin
         state_q    <= state_d;
         lvl_q      <= lvl_d;
         r15_q      <= r15_d;
         pc_q       <= pc_d;
         sr_q       <= sr_d;
         di_q       <= di_d;
         vec_q      <= vec_d;
         vec_ok_q   <= vec_ok_d;
         int_acp_q  <= int_acp_d;
         int_ack_q  <= int_ack_d;
         vect_req_q <= vect_req_d;
         mem_a_q    <= mem_a_d;
         mem_do_q   <= mem_do_d;
         mem_we_q   <= mem_we_d;
         mem_req_q  <= mem_req_d;
         exc_busy_q <= exc_busy_d;
         exc_done_q <= exc_done_d;
         new_pc_q   <= new_pc_d;
         new_r15_q  <= new_r15_d;
         new_sr_i_q <= new_sr_i_d;
      end
   end

   assign INT_MASK = SR_I;
   assign MEM_BA   = 4'hF;
   assign INT_ACP  = int_acp_q;
   assign INT_ACK  = int_ack_q;
   assign VECT_REQ = vect_req_q;
   assign MEM_A    = mem_a_q;
   assign MEM_DO   = mem_do_q;
   assign MEM_WE   = mem_we_q;
   assign MEM_REQ  = mem_req_q;
   assign EXC_BUSY = exc_busy_q;
   assign EXC_DONE = exc_done_q;
   assign NEW_PC   = new_pc_q;
   assign NEW_R15  = new_r15_q;
   assign NEW_SR_I = new_sr_i_q;

endmodule

// File: tb/tb_sh2_int_accept.sv
// Bench for sh2_int_accept: a table of directed interrupt requests plus hand sequences
// for vector-fetch wait, bus wait and reset in the middle of a sequence.
module tb_sh2_int_accept;

   localparam logic [31:0] DI_KEY = 32'hA5A5_0000;

   logic        CLK, RST_N, CE_R, CE_F;
   logic [3:0]  SR_I;
   logic        INST_BOUND;
   logic [31:0] PC, SR, R15, VBR;
   logic [3:0]  INT_MASK;
   logic        INT_REQ;
   logic [3:0]  INT_LVL;
   logic [7:0]  INT_VEC;
   logic        INT_ACP, INT_ACK, VECT_REQ, VECT_WAIT;
   logic [31:0] MEM_A, MEM_DO, MEM_DI;
   logic [3:0]  MEM_BA;
   logic        MEM_WE, MEM_REQ, MEM_WAIT;
   logic        EXC_BUSY, EXC_DONE;
   logic [31:0] NEW_PC, NEW_R15;
   logic [3:0]  NEW_SR_I;

   sh2_int_accept dut (
      .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F),
      .SR_I(SR_I), .INST_BOUND(INST_BOUND), .PC(PC), .SR(SR), .R15(R15), .VBR(VBR),
      .INT_MASK(INT_MASK), .INT_REQ(INT_REQ), .INT_LVL(INT_LVL), .INT_VEC(INT_VEC),
      .INT_ACP(INT_ACP), .INT_ACK(INT_ACK), .VECT_REQ(VECT_REQ), .VECT_WAIT(VECT_WAIT),
      .MEM_A(MEM_A), .MEM_DO(MEM_DO), .MEM_DI(MEM_DI), .MEM_BA(MEM_BA),
      .MEM_WE(MEM_WE), .MEM_REQ(MEM_REQ), .MEM_WAIT(MEM_WAIT),
      .EXC_BUSY(EXC_BUSY), .EXC_DONE(EXC_DONE),
      .NEW_PC(NEW_PC), .NEW_R15(NEW_R15), .NEW_SR_I(NEW_SR_I)
   );

   // memory returns a fixed function of the address so the handler PC is predictable
   assign MEM_DI = MEM_A ^ DI_KEY;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // rising and falling phase enables alternate clock by clock
   initial begin
      CE_R = 1'b0;
      CE_F = 1'b0;
      forever begin
         @(negedge CLK);
         CE_R = ~CE_R;
         CE_F = ~CE_R;
      end
   end

   int          acp_cnt, ack_cnt, vreq_cnt, mreq_cnt, log_n;
   logic [31:0] log_a  [64];
   logic [31:0] log_d  [64];
   logic        log_we [64];

   always @(posedge CLK) begin
      if (RST_N) begin
         if (VECT_REQ) vreq_cnt <= vreq_cnt + 1;
         if (MEM_REQ)  mreq_cnt <= mreq_cnt + 1;
         if (CE_R) begin
            if (INT_ACP) acp_cnt <= acp_cnt + 1;
            if (INT_ACK) ack_cnt <= ack_cnt + 1;
            if (MEM_REQ && !MEM_WAIT) begin
               log_a[6'(log_n)]  <= MEM_A;
               log_d[6'(log_n)]  <= MEM_DO;
               log_we[6'(log_n)] <= MEM_WE;
               log_n             <= log_n + 1;
            end
         end
      end
   end

   int n_chk, n_pass;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step_r();
      @(posedge CLK);
      while (!CE_R) @(posedge CLK);
      #1;
   endtask

   task automatic step_f();
      @(posedge CLK);
      while (!CE_F) @(posedge CLK);
      #1;
   endtask

   task automatic wait_acp(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 10 && !ok; k++) begin
         step_r();
         if (INT_ACP) ok = 1'b1;
      end
      INT_REQ = 1'b0;
   endtask

   task automatic wait_done(output int n, output bit ok);
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 40) begin
         step_r();
         n++;
         if (EXC_DONE) ok = 1'b1;
      end
   endtask

   task automatic chk_reset(input string tag, input logic [3:0] mask);
      chk({tag, "_strobes"}, {INT_ACP, INT_ACK, VECT_REQ, MEM_REQ, MEM_WE, EXC_BUSY, EXC_DONE}, 7'd0);
      chk({tag, "_bus"}, {MEM_A, MEM_DO}, 64'd0);
      chk({tag, "_new"}, {NEW_PC, NEW_SR_I}, 36'd0);
      chk({tag, "_new_r15"}, NEW_R15, 32'd0);
      chk({tag, "_ba_mask"}, {MEM_BA, INT_MASK}, {4'hF, mask});
   endtask

   task automatic check_seq(input string tag, input int base,
                            input logic [31:0] a_psr, input logic [31:0] a_ppc,
                            input logic [31:0] a_rvec, input logic [31:0] sr_v,
                            input logic [31:0] pc_v, input logic [3:0] nsri);
      logic [5:0] i0, i1, i2;
      i0 = 6'(base);
      i1 = 6'(base + 1);
      i2 = 6'(base + 2);
      chk({tag, "_nbus"}, 64'(log_n - base), 64'd3);
      chk({tag, "_psr_a"}, log_a[i0], a_psr);
      chk({tag, "_psr_d"}, {log_we[i0], log_d[i0]}, {1'b1, sr_v});
      chk({tag, "_ppc_a"}, log_a[i1], a_ppc);
      chk({tag, "_ppc_d"}, {log_we[i1], log_d[i1]}, {1'b1, pc_v});
      chk({tag, "_rvec_a"}, {log_we[i2], log_a[i2]}, {1'b0, a_rvec});
      chk({tag, "_new_pc"}, NEW_PC, a_rvec ^ DI_KEY);
      chk({tag, "_new_r15"}, NEW_R15, a_ppc);
      chk({tag, "_new_sr_i"}, NEW_SR_I, nsri);
   endtask

   typedef struct {
      logic [3:0]  sr_i;
      logic [3:0]  lvl;
      logic [7:0]  vec;
      logic        bnd;
      logic [31:0] r15;
      logic [31:0] vbr;
      logic        acc;
      logic [31:0] a_psr;
      logic [31:0] a_ppc;
      logic [31:0] a_rvec;
      logic [3:0]  nsri;
   } vec_t;

   vec_t tv [8];

   initial begin
      bit          ok;
      int          n, base, a0, k0, v0, m0;
      logic [31:0] pc_v, sr_v;
      string       tag;

      tv[0] = '{4'd3,  4'd5,  8'h40, 1'b1, 32'h0600_1000, 32'h0600_0000, 1'b1,
                32'h0600_0FFC, 32'h0600_0FF8, 32'h0600_0100, 4'd5};
      tv[1] = '{4'd3,  4'd3,  8'h40, 1'b1, 32'h0600_1000, 32'h0600_0000, 1'b0,
                32'h0, 32'h0, 32'h0, 4'd0};
      tv[2] = '{4'd15, 4'd15, 8'h0B, 1'b1, 32'h0600_1000, 32'h0600_0000, 1'b1,
                32'h0600_0FFC, 32'h0600_0FF8, 32'h0600_002C, 4'd15};
      tv[3] = '{4'd0,  4'd1,  8'hFF, 1'b1, 32'h0000_0000, 32'hFFFF_FF00, 1'b1,
                32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h0000_02FC, 4'd1};
      tv[4] = '{4'd14, 4'd15, 8'h20, 1'b1, 32'h0000_0010, 32'h0000_0000, 1'b1,
                32'h0000_000C, 32'h0000_0008, 32'h0000_0080, 4'd15};
      tv[5] = '{4'd5,  4'd4,  8'h0C, 1'b1, 32'h0600_1000, 32'h0600_0000, 1'b0,
                32'h0, 32'h0, 32'h0, 4'd0};
      tv[6] = '{4'd3,  4'd5,  8'h40, 1'b0, 32'h0600_1000, 32'h0600_0000, 1'b0,
                32'h0, 32'h0, 32'h0, 4'd0};
      tv[7] = '{4'd8,  4'd2,  8'h0B, 1'b1, 32'h8000_0004, 32'h0000_0000, 1'b1,
                32'h8000_0000, 32'h7FFF_FFFC, 32'h0000_002C, 4'd2};

      RST_N = 1'b0;
      SR_I = 4'h9; INST_BOUND = 1'b0; PC = '0; SR = '0; R15 = '0; VBR = '0;
      INT_REQ = 1'b0; INT_LVL = '0; INT_VEC = '0; VECT_WAIT = 1'b0; MEM_WAIT = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk_reset("rst", 4'h9);
      RST_N = 1'b1;
      SR_I = 4'h2;
      #1;
      chk("int_mask", INT_MASK, 4'h2);

      for (int i = 0; i < 8; i++) begin
         tag        = $sformatf("tv%0d", i);
         SR_I       = tv[i].sr_i;
         INT_LVL    = tv[i].lvl;
         INT_VEC    = tv[i].vec;
         INST_BOUND = tv[i].bnd;
         R15        = tv[i].r15;
         VBR        = tv[i].vbr;
         pc_v       = 32'h0C00_0100 + 32'(i * 2);
         sr_v       = 32'h0000_00F0 | 32'(i);
         PC         = pc_v;
         SR         = sr_v;
         base = log_n; a0 = acp_cnt; k0 = ack_cnt; v0 = vreq_cnt; m0 = mreq_cnt;
         INT_REQ = 1'b1;
         if (tv[i].acc) begin
            wait_acp(ok);
            chk({tag, "_acp"}, 64'(ok), 64'd1);
            chk({tag, "_busy"}, EXC_BUSY, 1'b1);
            wait_done(n, ok);
            chk({tag, "_done"}, 64'(ok), 64'd1);
            chk({tag, "_latency"}, 64'(n), 64'd6);
            chk({tag, "_ack_pulses"}, 64'(ack_cnt - k0), 64'd1);
            check_seq(tag, base, tv[i].a_psr, tv[i].a_ppc, tv[i].a_rvec, sr_v, pc_v, tv[i].nsri);
            step_r();
            chk({tag, "_busy_after"}, {EXC_BUSY, EXC_DONE}, 2'b00);
         end else begin
            repeat (20) step_r();
            INT_REQ = 1'b0;
            chk({tag, "_no_acp"}, 64'(acp_cnt - a0), 64'd0);
            chk({tag, "_no_vreq"}, 64'(vreq_cnt - v0), 64'd0);
            chk({tag, "_no_mreq"}, 64'(mreq_cnt - m0), 64'd0);
         end
      end

      // vector fetch held off by VECT_WAIT while the INTC changes its vector
      SR_I = 4'd3; INT_LVL = 4'd5; INT_VEC = 8'h41; INST_BOUND = 1'b1;
      R15 = 32'h0600_2000; VBR = 32'h0600_0000; PC = 32'h0000_4444; SR = 32'h0000_0033;
      VECT_WAIT = 1'b1;
      base = log_n; k0 = ack_cnt;
      INT_REQ = 1'b1;
      wait_acp(ok);
      chk("vw_acp", 64'(ok), 64'd1);
      for (int i = 0; i < 5; i++) begin
         step_f();
         INT_VEC = 8'h42 + 8'(i);
      end
      chk("vw_no_ack_yet", 64'(ack_cnt - k0), 64'd0);
      chk("vw_vreq_low", VECT_REQ, 1'b0);
      INT_VEC   = 8'h47;
      VECT_WAIT = 1'b0;
      step_f();
      INT_VEC = 8'h55;
      wait_done(n, ok);
      chk("vw_done", 64'(ok), 64'd1);
      chk("vw_ack_pulses", 64'(ack_cnt - k0), 64'd1);
      check_seq("vw", base, 32'h0600_1FFC, 32'h0600_1FF8, 32'h0600_011C,
                32'h0000_0033, 32'h0000_4444, 4'd5);
      step_r();

      // bus wait while pushing PC
      SR_I = 4'd0; INT_LVL = 4'd7; INT_VEC = 8'h10;
      R15 = 32'h0010_0000; VBR = 32'h0020_0000; PC = 32'h1234_5678; SR = 32'h0000_00A0;
      base = log_n;
      INT_REQ = 1'b1;
      wait_acp(ok);
      chk("mw_acp", 64'(ok), 64'd1);
      ok = 1'b0;
      for (int k = 0; k < 10 && !ok; k++) begin
         step_r();
         if (MEM_REQ && MEM_WE && MEM_A == 32'h000F_FFF8) ok = 1'b1;
      end
      chk("mw_ppc_reached", 64'(ok), 64'd1);
      MEM_WAIT = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step_r();
         chk($sformatf("mw_hold_a%0d", k), MEM_A, 32'h000F_FFF8);
         chk($sformatf("mw_hold_d%0d", k), {MEM_REQ, MEM_WE, MEM_DO}, {2'b11, 32'h1234_5678});
      end
      chk("mw_nbus_hold", 64'(log_n - base), 64'd1);
      MEM_WAIT = 1'b0;
      step_r();
      chk("mw_rvec_start", {MEM_REQ, MEM_WE, MEM_A}, {2'b10, 32'h0020_0040});
      wait_done(n, ok);
      chk("mw_done", 64'(ok), 64'd1);
      check_seq("mw", base, 32'h000F_FFFC, 32'h000F_FFF8, 32'h0020_0040,
                32'h0000_00A0, 32'h1234_5678, 4'd7);
      step_r();

      // reset in the middle of the SR push, then a fresh full sequence
      SR_I = 4'd1; INT_LVL = 4'd2; INT_VEC = 8'h20;
      R15 = 32'h0000_3000; VBR = 32'h0; PC = 32'h0000_0100; SR = 32'h0000_0010;
      INT_REQ = 1'b1;
      wait_acp(ok);
      chk("rs_acp", 64'(ok), 64'd1);
      ok = 1'b0;
      for (int k = 0; k < 10 && !ok; k++) begin
         step_r();
         if (MEM_REQ && MEM_WE) ok = 1'b1;
      end
      chk("rs_psr_reached", {63'(ok), MEM_A == 32'h0000_2FFC}, 64'd3);
      RST_N = 1'b0;
      #1;
      chk_reset("rs", 4'd1);
      base = log_n; a0 = acp_cnt; m0 = mreq_cnt;
      repeat (4) @(posedge CLK);
      #1;
      RST_N = 1'b1;
      repeat (6) step_r();
      chk("rs_quiet", {32'(mreq_cnt - m0), 32'(acp_cnt - a0)}, 64'd0);
      chk("rs_no_bus", 64'(log_n - base), 64'd0);
      SR_I = 4'd3; INT_LVL = 4'd5; INT_VEC = 8'h40;
      R15 = 32'h0600_1000; VBR = 32'h0600_0000; PC = 32'h0000_0ABC; SR = 32'h0000_0030;
      base = log_n;
      INT_REQ = 1'b1;
      wait_acp(ok);
      chk("rs2_acp", 64'(ok), 64'd1);
      wait_done(n, ok);
      chk("rs2_done", 64'(ok), 64'd1);
      chk("rs2_latency", 64'(n), 64'd6);
      check_seq("rs2", base, 32'h0600_0FFC, 32'h0600_0FF8, 32'h0600_0100,
                32'h0000_0030, 32'h0000_0ABC, 4'd5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
